// File: rtl/naive_bus_xbar.sv
// naive_bus_xbar: N-master / M-slave shared bus, one transaction per cycle, with
// fixed-priority or round-robin arbitration, registered read return and decode-error logging.
module naive_bus_xbar #(
  parameter int                    N_MASTER    = 3,
  parameter int                    N_SLAVE     = 4,
  parameter logic [32*N_SLAVE-1:0] SLAVES_MASK = {N_SLAVE{32'h0000_0fff}},
  parameter logic [32*N_SLAVE-1:0] SLAVES_BASE = {32'h0003_0000, 32'h0002_0000,
                                                  32'h0001_0000, 32'h0000_0000},
  parameter int                    ARB_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MASTER-1:0]     m_rd_req,
  input  logic [N_MASTER-1:0]     m_wr_req,
  output logic [N_MASTER-1:0]     m_rd_gnt,
  output logic [N_MASTER-1:0]     m_wr_gnt,
  input  logic [32*N_MASTER-1:0]  m_rd_addr,
  input  logic [32*N_MASTER-1:0]  m_wr_addr,
  input  logic [32*N_MASTER-1:0]  m_wr_data,
  input  logic [4*N_MASTER-1:0]   m_wr_be,
  output logic [32*N_MASTER-1:0]  m_rd_data,
  output logic [N_SLAVE-1:0]      s_rd_req,
  output logic [N_SLAVE-1:0]      s_wr_req,
  input  logic [N_SLAVE-1:0]      s_rd_gnt,
  input  logic [N_SLAVE-1:0]      s_wr_gnt,
  output logic [32*N_SLAVE-1:0]   s_rd_addr,
  output logic [32*N_SLAVE-1:0]   s_wr_addr,
  output logic [32*N_SLAVE-1:0]   s_wr_data,
  output logic [4*N_SLAVE-1:0]    s_wr_be,
  input  logic [32*N_SLAVE-1:0]   s_rd_data,
  output logic [15:0]             o_decerr_cnt,
  output logic [31:0]             o_decerr_addr
);

  localparam int MW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  logic [MW-1:0]       ptr, ptr_next, win_idx;
  logic [N_MASTER-1:0] active, ge_ptr, win_oh;
  logic                any_req, do_wr, do_rd, hit, sel_gnt, granted;
  logic [N_SLAVE-1:0]  hit_oh;
  logic [31:0]         sel_addr, sel_wdata, ret_data;
  logic [3:0]          sel_be;
  logic                rd_valid, rd_err;
  logic [N_MASTER-1:0] rd_master_oh;
  logic [N_SLAVE-1:0]  rd_slave_oh;

  function automatic logic [N_MASTER-1:0] first_master(input logic [N_MASTER-1:0] v);
    logic [N_MASTER-1:0] r;
    r = '0;
    for (int i = 0; i < N_MASTER; i++)
      if (v[i] && r == '0) r[i] = 1'b1;
    return r;
  endfunction

  // Round-robin searches masters at or above the pointer first, then wraps to the bottom.
  always_comb begin
    active  = m_rd_req | m_wr_req;
    any_req = |active;
    ge_ptr  = '0;
    for (int i = 0; i < N_MASTER; i++) ge_ptr[i] = (i >= int'(ptr));
    if (ARB_MODE == 1 && (active & ge_ptr) != '0) win_oh = first_master(active & ge_ptr);
    else                                           win_oh = first_master(active);
    win_idx = '0;
    for (int i = 0; i < N_MASTER; i++)
      if (win_oh[i]) win_idx = MW'(i);
    ptr_next  = (win_idx == MW'(N_MASTER - 1)) ? '0 : win_idx + 1'b1;
    do_wr     = |(win_oh & m_wr_req);
    do_rd     = any_req && !do_wr;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (win_oh[i]) begin
        sel_addr  = do_wr ? m_wr_addr[32*i +: 32] : m_rd_addr[32*i +: 32];
        sel_wdata = m_wr_data[32*i +: 32];
        sel_be    = m_wr_be[4*i +: 4];
      end
    end
  end

  always_comb begin
    hit_oh = '0;
    for (int i = 0; i < N_SLAVE; i++)
      if (hit_oh == '0 && (sel_addr & ~SLAVES_MASK[32*i +: 32]) == SLAVES_BASE[32*i +: 32])
        hit_oh[i] = 1'b1;
    hit     = |hit_oh;
    sel_gnt = |(hit_oh & (do_wr ? s_wr_gnt : s_rd_gnt));
    granted = any_req && (!hit || sel_gnt);
  end

  // A decode miss never reaches a slave but is granted at once so the master cannot hang.
  always_comb begin
    s_rd_req  = '0;
    s_wr_req  = '0;
    s_rd_addr = '0;
    s_wr_addr = '0;
    s_wr_data = '0;
    s_wr_be   = '0;
    m_rd_gnt  = '0;
    m_wr_gnt  = '0;
    if (any_req) begin
      for (int i = 0; i < N_SLAVE; i++) begin
        if (hit_oh[i]) begin
          if (do_wr) begin
            s_wr_req[i]         = 1'b1;
            s_wr_addr[32*i +: 32] = sel_addr;
            s_wr_data[32*i +: 32] = sel_wdata;
            s_wr_be[4*i +: 4]     = sel_be;
          end else begin
            s_rd_req[i]         = 1'b1;
            s_rd_addr[32*i +: 32] = sel_addr;
          end
        end
      end
      if (do_wr) m_wr_gnt = win_oh & {N_MASTER{granted}};
      else       m_rd_gnt = win_oh & {N_MASTER{granted}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      rd_valid      <= 1'b0;
      rd_err        <= 1'b0;
      rd_master_oh  <= '0;
      rd_slave_oh   <= '0;
      o_decerr_cnt  <= '0;
      o_decerr_addr <= '0;
    end else begin
      if (ARB_MODE == 1 && N_MASTER > 1 && granted) ptr <= ptr_next;
      rd_valid     <= do_rd && granted;
      rd_err       <= !hit;
      rd_master_oh <= win_oh;
      rd_slave_oh  <= hit_oh;
      if (any_req && !hit) begin
        if (o_decerr_cnt != 16'hffff) o_decerr_cnt <= o_decerr_cnt + 16'd1;
        o_decerr_addr <= sel_addr;
      end
    end
  end

  // Slave read data arrives the cycle after its grant, so it is steered by last cycle's winner.
  always_comb begin
    ret_data  = '0;
    m_rd_data = '0;
    for (int i = 0; i < N_SLAVE; i++)
      if (rd_slave_oh[i]) ret_data = s_rd_data[32*i +: 32];
    for (int j = 0; j < N_MASTER; j++)
      if (rd_valid && !rd_err && rd_master_oh[j]) m_rd_data[32*j +: 32] = ret_data;
  end

endmodule
